lm75a_poll_sched: RTL

Transaction sequencer that periodically reads the LM75A temperature register through a byte-level I2C master.

---
 rtl/lm75a_pkg.sv | 27 ++
 rtl/lm75a_poll_timer.sv | 47 ++++
 rtl/lm75a_poll_sched.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lm75a_pkg.sv
// Shared encodings for the LM75A poll sequencer.
// Byte-master opcodes, sequencer states and the temperature pointer.
package lm75a_pkg;

  localparam logic [2:0] OP_START  = 3'd0;
  localparam logic [2:0] OP_RSTART = 3'd1;
  localparam logic [2:0] OP_WRITE  = 3'd2;
  localparam logic [2:0] OP_READ   = 3'd3;
  localparam logic [2:0] OP_STOP   = 3'd4;

  localparam logic [7:0] LM75A_PTR_TEMP = 8'h00;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_AW,
    S_PTR,
    S_RS,
    S_AR,
    S_RDM,
    S_RDL,
    S_STOP,
    S_ABORT,
    S_DONE
  } state_e;

endpackage

// File: rtl/lm75a_poll_timer.sv
// Poll-interval divider plus the request flag that collapses
// timer ticks and manual triggers into one pending read.
module lm75a_poll_timer #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned POLL_MS = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic trigger,
  input  logic clr,
  output logic pending
);

  localparam longint unsigned PERIOD =
    (64'(POLL_MS) * 64'(CLK_HZ)) / 64'd1000;
  localparam int CW = (PERIOD < 2) ? 1 : $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam bit HAS_POLL = (PERIOD != 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          tick;

  always_comb begin
    tick = HAS_POLL && enable && (cnt_q == LAST);
    cnt_d = '0;
    if (HAS_POLL && enable && !tick) begin
      cnt_d = cnt_q + 1'b1;
    end
    // A request landing in the same cycle as the clear is kept.
    pending_d = (pending_q & ~clr) | tick | trigger;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/lm75a_poll_sched.sv
// LM75A temperature read sequencer driving a byte-level I2C master,
// with NACK/timeout retries and a decoded temperature output.
module lm75a_poll_sched #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned POLL_MS     = 250,
  parameter logic [6:0]  DEV_ADDR    = 7'h48,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        trigger,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_op,
  output logic [7:0]  cmd_data,
  output logic        cmd_nack,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_nack,
  output logic        busy,
  output logic [15:0] temp_raw,
  output logic [10:0] temp_c,
  output logic        temp_valid,
  output logic        err,
  output logic [7:0]  err_cnt
);

  import lm75a_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e        state_q, state_d;
  logic          issued_q, issued_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    retry_q, retry_d;
  logic [7:0]    msb_q, msb_d, lsb_q, lsb_d;
  logic [15:0]   temp_raw_q, temp_raw_d;
  logic [10:0]   temp_c_q, temp_c_d;
  logic          temp_valid_q, temp_valid_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          pending, pend_clr;
  logic          is_cmd, fail, exhaust;

  lm75a_poll_timer #(
    .CLK_HZ  (CLK_HZ),
    .POLL_MS (POLL_MS)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .trigger (trigger),
    .clr     (pend_clr),
    .pending (pending)
  );

  always_comb begin
    state_d      = state_q;
    issued_d     = issued_q;
    tmo_d        = tmo_q;
    retry_d      = retry_q;
    msb_d        = msb_q;
    lsb_d        = lsb_q;
    temp_raw_d   = temp_raw_q;
    temp_c_d     = temp_c_q;
    temp_valid_d = 1'b0;
    err_d        = 1'b0;
    err_cnt_d    = err_cnt_q;
    pend_clr     = 1'b0;
    fail         = 1'b0;
    exhaust      = 1'b0;
    is_cmd       = 1'b1;
    cmd_op       = OP_START;
    cmd_data     = 8'h00;
    cmd_nack     = 1'b0;

    unique case (state_q)
      S_START: cmd_op = OP_START;
      S_AW: begin
        cmd_op   = OP_WRITE;
        cmd_data = {DEV_ADDR, 1'b0};
      end
      S_PTR: begin
        cmd_op   = OP_WRITE;
        cmd_data = LM75A_PTR_TEMP;
      end
      S_RS: cmd_op = OP_RSTART;
      S_AR: begin
        cmd_op   = OP_WRITE;
        cmd_data = {DEV_ADDR, 1'b1};
      end
      S_RDM: cmd_op = OP_READ;
      S_RDL: begin
        cmd_op   = OP_READ;
        cmd_nack = 1'b1;
      end
      S_STOP, S_ABORT: cmd_op = OP_STOP;
      default: is_cmd = 1'b0;
    endcase

    cmd_valid = is_cmd & ~issued_q;

    if (state_q == S_IDLE) begin
      if (pending) begin
        state_d  = S_START;
        pend_clr = 1'b1;
      end
    end else if (state_q == S_DONE) begin
      temp_raw_d   = {msb_q, lsb_q};
      temp_c_d     = {msb_q, lsb_q[7:5]};
      temp_valid_d = 1'b1;
      retry_d      = 8'd0;
      state_d      = S_IDLE;
    end else if (!issued_q) begin
      if (cmd_ready) begin
        issued_d = 1'b1;
        tmo_d    = '0;
      end
    end else if (rsp_valid) begin
      issued_d = 1'b0;
      unique case (state_q)
        S_START: state_d = S_AW;
        S_AW:    state_d = rsp_nack ? S_ABORT : S_PTR;
        S_PTR:   state_d = rsp_nack ? S_ABORT : S_RS;
        S_RS:    state_d = S_AR;
        S_AR:    state_d = rsp_nack ? S_ABORT : S_RDM;
        S_RDM: begin
          msb_d   = rsp_data;
          state_d = S_RDL;
        end
        S_RDL: begin
          lsb_d   = rsp_data;
          state_d = S_STOP;
        end
        S_STOP:  state_d = S_DONE;
        default: fail = 1'b1;
      endcase
    end else if (tmo_q == TMO_LAST) begin
      issued_d = 1'b0;
      // A hung recovery STOP is not worth retrying.
      if (state_q == S_ABORT) begin
        exhaust = 1'b1;
      end else begin
        state_d = S_ABORT;
      end
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    if (fail) begin
      if (retry_q < 8'(MAX_RETRY)) begin
        retry_d = retry_q + 8'd1;
        state_d = S_START;
      end else begin
        exhaust = 1'b1;
      end
    end

    if (exhaust) begin
      err_d     = 1'b1;
      err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
      retry_d   = 8'd0;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      issued_q     <= 1'b0;
      tmo_q        <= '0;
      retry_q      <= 8'd0;
      msb_q        <= 8'd0;
      lsb_q        <= 8'd0;
      temp_raw_q   <= 16'd0;
      temp_c_q     <= 11'd0;
      temp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      tmo_q        <= tmo_d;
      retry_q      <= retry_d;
      msb_q        <= msb_d;
      lsb_q        <= lsb_d;
      temp_raw_q   <= temp_raw_d;
      temp_c_q     <= temp_c_d;
      temp_valid_q <= temp_valid_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign temp_raw   = temp_raw_q;
  assign temp_c     = temp_c_q;
  assign temp_valid = temp_valid_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;

endmodule
